// File: rtl/byte_frame_pkg.sv
// Shared types and constants for the byte frame serializer.
package byte_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } ser_state_t;

    localparam int         FRAME_BITS  = 10;
    localparam logic       START_LEVEL = 1'b0;
    localparam logic       STOP_LEVEL  = 1'b1;
    localparam logic       IDLE_LEVEL  = 1'b1;
    localparam logic [7:0] DROP_MAX    = 8'hFF;

endpackage

// File: rtl/byte_frame_serializer_fifo.sv
// Circular-buffer FIFO with a combinational head and occupancy-based flags.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/byte_frame_serializer.sv
// Buffers upstream bytes and sends each as start + 8 data (LSB first) + stop.
module byte_frame_serializer
    import byte_frame_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] __in0,
    input  logic       __in1,
    output logic       __out0,
    output logic       __out1,
    output logic [7:0] __out2,
    output logic       __out3
);

    localparam int              CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0]   CYC_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]      LAST_BIT = 3'(FRAME_BITS - 3);

    ser_state_t    state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [7:0]    drop_cnt;
    logic          line;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       push;
    logic       pop;
    logic       bit_done;

    assign __out1   = ~fifo_full;
    assign push     = __in1 & __out1;
    assign bit_done = (cyc_cnt == '0);
    // The head is taken either from idle or at the last stop cycle, so frames abut.
    assign pop      = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (__in0),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Count rejected offers, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (__in1 && !__out1 && drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Frame sequencer; the line level is registered one step ahead of each bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            line    <= IDLE_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    line <= IDLE_LEVEL;
                    if (pop) begin
                        shift   <= fifo_dout;
                        bit_cnt <= '0;
                        cyc_cnt <= CYC_LOAD;
                        line    <= START_LEVEL;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cyc_cnt <= CYC_LOAD;
                        line    <= shift[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cyc_cnt <= CYC_LOAD;
                        if (bit_cnt == LAST_BIT) begin
                            line  <= STOP_LEVEL;
                            state <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            line    <= shift[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift   <= fifo_dout;
                            bit_cnt <= '0;
                            cyc_cnt <= CYC_LOAD;
                            line    <= START_LEVEL;
                            state   <= START;
                        end else begin
                            line  <= IDLE_LEVEL;
                            state <= IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                default: begin
                    line  <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign __out0 = line;
    assign __out2 = drop_cnt;
    assign __out3 = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_byte_frame_serializer.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes and compares.
module tb_byte_frame_serializer;

    localparam int BC = 4;
    localparam int FL = 10 * BC;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in0;
    logic       in1;
    logic       out0;
    logic       out1;
    logic [7:0] out2;
    logic       out3;

    always #5 clk = ~clk;

    byte_frame_serializer #(
        .DEPTH      (4),
        .BIT_CYCLES (BC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .__in0  (in0),
        .__in1  (in1),
        .__out0 (out0),
        .__out1 (out1),
        .__out2 (out2),
        .__out3 (out3)
    );

    typedef struct {
        logic [7:0] data;
        bit         chk_gap;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b, input bit chk_gap, input int gap);
        exp_t e;
        e.data    = b;
        e.chk_gap = chk_gap;
        e.gap     = gap;
        sb.push_back(e);
    endtask

    // Cycle-by-cycle line levels of a well-formed frame, cycle 0 first.
    function automatic logic [FL-1:0] frame_of(input logic [7:0] b);
        logic [FL-1:0] v;
        for (int c = 0; c < FL; c++) begin
            int k;
            k = c / BC;
            if (k == 0)      v[c] = 1'b0;
            else if (k == 9) v[c] = 1'b1;
            else             v[c] = b[k-1];
        end
        return v;
    endfunction

    // Line monitor: a low sample while hunting starts a frame of FL samples.
    initial begin : monitor
        bit            infr;
        int            c;
        int            idle;
        int            gap;
        logic [FL-1:0] lv;
        exp_t          e;
        infr = 0; c = 0; idle = 0; gap = 0; lv = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                infr = 0;
                idle = 0;
            end else if (!infr) begin
                if (out0 === 1'b0) begin
                    infr = 1;
                    c    = 1;
                    lv   = '0;
                    gap  = idle;
                end else begin
                    idle++;
                end
            end else begin
                lv[c] = out0;
                c++;
                if (c == FL) begin
                    infr = 0;
                    idle = 0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got %0h want none", lv);
                    end else begin
                        e = sb.pop_front();
                        check("frame", lv, frame_of(e.data));
                        if (e.chk_gap) check("inter_frame_gap", gap, e.gap);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (out3 !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (out3 !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy %0b after %0d cycles want 0", out3, n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Five accepted bytes fill the FIFO (first is popped), then nrej rejected offers.
    task automatic fill_and_flood(input logic [7:0] base, input int nrej, input bit chk_ready);
        for (int i = 0; i < 5 + nrej; i++) begin
            @(negedge clk);
            if (chk_ready) check("ready_cycle", out1, (i < 5) ? 1 : 0);
            in0 = 8'(base + 8'(i));
            in1 = 1'b1;
            if (i < 5) expect_byte(8'(base + 8'(i)), 0, 0);
        end
        @(negedge clk);
        in1 = 1'b0;
    endtask

    initial begin : stimulus
        int j;
        int bad;
        int exp_drop;
        rst = 1'b1;
        in0 = '0;
        in1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_line",  out0, 1);
        check("reset_ready", out1, 1);
        check("reset_drop",  out2, 0);
        check("reset_busy",  out3, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: latency to start bit and busy duration.
        in0 = 8'hA5;
        in1 = 1'b1;
        expect_byte(8'hA5, 0, 0);
        @(negedge clk);
        in1 = 1'b0;
        j = 0;
        while (out0 === 1'b1 && j < 10) begin
            @(negedge clk);
            j++;
        end
        check("start_latency", j, 1);
        while (out3 === 1'b1 && j < 100) begin
            @(negedge clk);
            j++;
        end
        check("busy_fall", j, 41);
        wait_idle(100);

        // Back-to-back frames with no idle gap.
        @(negedge clk);
        in0 = 8'h00;
        in1 = 1'b1;
        expect_byte(8'h00, 0, 0);
        @(negedge clk);
        in0 = 8'hFF;
        expect_byte(8'hFF, 1, 0);
        @(negedge clk);
        in1 = 1'b0;
        wait_idle(200);

        // Overflow: 10 offers, 5 accepted, 5 dropped.
        fill_and_flood(8'h10, 5, 1);
        check("drop_overflow", out2, 5);
        wait_idle(300);

        // Drop saturation: 300 more rejected offers in bursts.
        exp_drop = 5;
        for (int b = 0; b < 10; b++) begin
            fill_and_flood(8'(8'h40 + 8'(b * 8)), 30, 0);
            exp_drop = (exp_drop + 30 > 255) ? 255 : exp_drop + 30;
            check("drop_sat", out2, exp_drop);
            wait_idle(300);
        end

        // Reset during data bit 3 of 8'h3C with two bytes queued.
        @(negedge clk);
        in0 = 8'h3C;
        in1 = 1'b1;
        expect_byte(8'h3C, 0, 0);
        @(negedge clk);
        in0 = 8'h11;
        expect_byte(8'h11, 0, 0);
        @(negedge clk);
        in0 = 8'h22;
        expect_byte(8'h22, 0, 0);
        @(negedge clk);
        in1 = 1'b0;
        repeat (16) @(negedge clk);
        check("busy_before_rst", out3, 1);
        rst = 1'b1;
        #1;
        check("rst_line",  out0, 1);
        check("rst_ready", out1, 1);
        check("rst_drop",  out2, 0);
        check("rst_busy",  out3, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (out0 !== 1'b1) bad++;
            if (out3 !== 1'b0) bad++;
        end
        check("quiet_after_rst", bad, 0);

        // Pointer wrap: nine spaced bytes, FIFO never fills.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("ready_wrap", out1, 1);
            in0 = 8'(i);
            in1 = 1'b1;
            expect_byte(8'(i), 0, 0);
            @(negedge clk);
            in1 = 1'b0;
            repeat (28) @(negedge clk);
        end
        wait_idle(500);

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d pending", sb.size());
        $fatal(1, "timeout");
    end

endmodule

// File: doc/byte_frame_serializer.md
# byte_frame_serializer

Downstream consumer of the 8-bit per-cycle result stream produced by the generated top-level core. Accepts bytes on a valid/ready handshake into a small FIFO and transmits each as an asynchronous-serial frame (start bit, 8 data bits LSB-first, stop bit) on a single line. Bytes offered while the FIFO is full are dropped and counted, because the upstream core cannot stall.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BIT_CYCLES, 4: clock cycles per serial bit; at least 1.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- __in0  input  8  byte from the upstream core's 8-bit output.
- __in1  input  1  valid strobe for __in0.
- __out0  output  1  serial line; idles high.
- __out1  output  1  ready: FIFO not full.
- __out2  output  8  saturating count of dropped bytes.
- __out3  output  1  busy: a frame is in progress or the FIFO is non-empty.

## Operation
- **Push:** on an edge where __in1=1 and __out1=1, __in0 is written to the FIFO tail.
- **Drop:** __in1=1 with __out1=0 discards the byte. __out2 increments and saturates at 8'hFF.
- **Ready:** __out1 is derived from the registered count only. A pop in the same cycle does not admit a push when full.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: __out0=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, load the bit counter with 0 and the cycle counter with BIT_CYCLES-1, and go to START.
  - START: __out0=0 for BIT_CYCLES cycles, then go to DATA.
  - DATA: __out0 = shift[0]. Every BIT_CYCLES cycles, shift right and increment the bit counter. After bit 7 completes, go to STOP.
  - STOP: __out0=1 for BIT_CYCLES cycles.
- **End of STOP:** if the FIFO is non-empty, pop and go directly to START (no idle cycle between frames); otherwise go to IDLE.
- **Frame length:** exactly 10*BIT_CYCLES cycles.
- **Drive:** __out0 is driven from a register, so it is glitch-free.
- **FIFO:** circular buffer with log2(DEPTH)-bit pointers wrapping modulo DEPTH and a count of width log2(DEPTH)+1. Push and pop in the same cycle leave count unchanged. Pop when empty never occurs.
- **Busy:** __out3 = (state != IDLE) or (count != 0).
- **Reset:** asynchronous and effective immediately, including mid-frame; the frame in progress is aborted and not resumed. Reset values: __out0=1, __out1=1, __out2=0, __out3=0, FIFO empty, state IDLE, all counters 0.

## Timing
- **Latency, empty and idle:** byte pushed at edge E. Pop and entry to START happen at edge E+1, so __out0 falls after E+1.
  - Data bit k occupies cycles E+1+(1+k)*BIT_CYCLES through E+(2+k)*BIT_CYCLES.
  - The stop bit ends at edge E+1+10*BIT_CYCLES.
- **Ready:** __out1 deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the pop that frees an entry.
- **Drop counter:** __out2 updates on the edge of the rejected offer.
- **Back-to-back bytes:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **Throughput:** sustained rate is one byte per 10*BIT_CYCLES cycles. A stall-free upstream overflows after DEPTH+1 bytes, because the first byte is popped.

## Structure
- **Shared package (byte_frame_pkg):**
  - state enum ser_state_t {IDLE, START, DATA, STOP};
  - constants FRAME_BITS=10, START_LEVEL=1'b0, STOP_LEVEL=1'b1, IDLE_LEVEL=1'b1;
  - DROP_MAX=8'hFF.
- **Sub-module byte_fifo:**
  - parameters DEPTH and WIDTH=8;
  - ports clk, rst, push, din, pop, dout (head, combinational), full, empty.
- **Top module:** the FSM, shift register, bit/cycle counters and drop counter.

## Test plan
- **Single byte:** reset, then push 8'hA5 once with BIT_CYCLES=4.
  - __out0 reads, per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - Frame is 40 cycles after the pop edge; __out3 falls after the stop bit.
- **Back-to-back:** push 8'h00 then 8'hFF on consecutive cycles.
  - Two 40-cycle frames with no idle cycle between.
  - Second frame's bits: 0, eight 1s, 1.
- **Overflow:** hold __in1=1 for 10 cycles with DEPTH=4.
  - 5 bytes are accepted; __out1=0 from cycle 6.
  - __out2=5 after 10 cycles; transmitted bytes match the first 5 in order.
- **Drop saturation:** keep the FIFO full and offer 300 rejected bytes.
  - __out2 stops at 8'hFF and never wraps.
- **Reset mid-frame:** assert rst during data bit 3 of 8'h3C with 2 bytes still queued.
  - __out0=1, __out1=1, __out2=0, __out3=0 immediately.
  - Nothing is transmitted after release until a new push.
- **Pointer wrap:** push/pop 9 distinct bytes (8'h01..8'h09) with spacing so the FIFO never fills.
  - All 9 are transmitted in order, exercising wrap of both pointers.
